// File: rtl/wb_uart_pkg.sv
// Shared definitions for the two-requester Wishbone arbiter in front of the
// wb_uart slave: FSM state encoding, grant encodings, UART register addresses
// and default bus widths.
package wb_uart_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  // wb_uart register map entries used by the requesters
  localparam logic [7:0] UART_RX_FIFO_ADDR = 8'h11;
  localparam logic [7:0] UART_TX_FIFO_ADDR = 8'h12;

  // One-hot grant encodings; bit n belongs to requester n
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for the two-requester arbiter.
// With rr_en low, m0 wins any tie. With rr_en high, a tie goes to the
// requester that did not win last time. A lone requester always wins.
module wb_arb_pick
  import wb_uart_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  input  logic       rr_en,
  output logic [1:0] winner
);

  // Resolve the one-hot winner from the current request vector
  always_comb begin
    winner = GNT_NONE;
    case (req)
      2'b01:   winner = GNT_M0;
      2'b10:   winner = GNT_M1;
      2'b11: begin
        if (rr_en && (last_grant == GNT_M0)) begin
          winner = GNT_M1;
        end else begin
          winner = GNT_M0;
        end
      end
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_uart_arbiter.sv
// Two-requester Wishbone arbiter in front of the wb_uart slave port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE: the winner's address,
// data and direction are latched at grant, the strobe is raised for the single
// ISSUE cycle, slave read data is captured at the end of WAIT, and the owner
// gets a one-cycle ack in DONE.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN to alternate ties between
// the requesters; by default m0 has fixed priority and no history is kept.
module wb_uart_arbiter
  import wb_uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_wb_we,
  output logic              o_wb_strobe,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [1:0]        o_grant
);

  arb_state_e  state;
  logic [1:0]  req_vec;
  logic [1:0]  last_grant;
  logic [1:0]  winner;
  logic        rr_mode;

  assign req_vec = {m1_req, m0_req};

`ifdef WB_ARB_ROUND_ROBIN_EN
  assign rr_mode = 1'b1;

  // Remember who won most recently so the next tie goes the other way;
  // starts at m1 so that m0 wins the first tie after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant <= GNT_M1;
    end else if ((state == ST_IDLE) && (winner != GNT_NONE)) begin
      last_grant <= winner;
    end
  end
`else
  // Fixed priority: no history register, the picker sees a constant
  assign rr_mode    = 1'b0;
  assign last_grant = GNT_M1;
`endif

  wb_arb_pick u_pick (
    .req        (req_vec),
    .last_grant (last_grant),
    .rr_en      (rr_mode),
    .winner     (winner)
  );

  // Transaction sequencer with all bus-facing outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_wb_strobe <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_rdata     <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      o_grant     <= GNT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          // Latch the winner's request; later input changes are ignored
          if (winner != GNT_NONE) begin
            o_grant     <= winner;
            o_wb_strobe <= 1'b1;
            if (winner[0]) begin
              o_wb_addr <= m0_addr;
              o_wb_data <= m0_wdata;
              o_wb_we   <= m0_we;
            end else begin
              o_wb_addr <= m1_addr;
              o_wb_data <= m1_wdata;
              o_wb_we   <= m1_we;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_wb_strobe <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Slave data is valid in this cycle; writes keep the old read data
          if (!o_wb_we) begin
            o_rdata <= i_wb_data;
          end
          m0_ack <= o_grant[0];
          m1_ack <= o_grant[1];
          state  <= ST_DONE;
        end
        ST_DONE: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          o_grant <= GNT_NONE;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_uart_arbiter.md
WB_UART_ARBITER -- requirements
Module: wb_uart_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of the write data and read data buses.
REQ-002 Parameter ADDR_W, default 32: width of the address buses.
REQ-003 i_clk  input  1  the single clock; all logic rises on its positive edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  input  1  requester n asks for one bus transaction.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  ADDR_W  target register address.
REQ-008 m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 m0_ack / m1_ack  output  1  one-cycle pulse when requester n's transaction completes.
REQ-010 o_rdata  output  DATA_W  read data, shared by both requesters, valid while ackN is high.
REQ-011 o_wb_addr, o_wb_data, o_wb_we, o_wb_strobe  output  ADDR_W, DATA_W, 1, 1  master side toward the wb_uart slave port.
REQ-012 i_wb_data  input  DATA_W  slave read data, valid one cycle after the strobe cycle.
REQ-013 o_grant  output  2  one-hot owner of the transaction in flight; 0 when IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT and DONE; every transition occurs on the i_clk edge.
REQ-015 IDLE: if any req is high, the arbiter picks a winner, latches that requester's addr, wdata and we into o_wb_*, sets o_grant, and moves to ISSUE. With no req it stays in IDLE.
REQ-016 ISSUE: o_wb_strobe=1 for exactly one cycle, then the FSM moves to WAIT.
REQ-017 WAIT: o_wb_strobe=0, and o_wb_addr, o_wb_data and o_wb_we hold their values. At the end of WAIT, o_rdata <= i_wb_data (reads only; writes leave o_rdata unchanged), then the FSM moves to DONE.
REQ-018 DONE: the granted ackN=1 for exactly one cycle, then the FSM moves to IDLE and o_grant is cleared.
REQ-019 Latency: req sampled at edge 0, strobe in cycle 1, ack in cycle 3; the next grant is possible at edge 4 at the earliest.
REQ-020 A requester drops req no later than the edge following its ack. A req still high in IDLE starts a new transaction.
REQ-021 The addr, wdata and we inputs are sampled only at grant; changes after grant have no effect.
REQ-022 A req deasserted before it is granted is silently dropped; it produces no ack.
REQ-023 No ack is ever issued to a non-granted requester; m0_ack and m1_ack are never high together.
REQ-024 o_wb_strobe is high only in ISSUE.

Reset
REQ-025 Asserting i_rst_n low immediately forces state=IDLE, o_wb_strobe=0, o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_rdata=0, acks=0, o_grant=0 and last_grant=m1, so that m0 wins first.
REQ-026 Reset in the middle of a transaction aborts it with no ack; after release, arbitration restarts from IDLE.

Configuration
REQ-027 Macro WB_ARB_ROUND_ROBIN_EN, when defined: on simultaneous requests the arbiter grants the requester other than last_grant, and last_grant updates on every grant.
REQ-028 Without WB_ARB_ROUND_ROBIN_EN: fixed priority, m0 always wins ties, and the last_grant register is not built.
REQ-029 A single requester is granted identically in both builds.

Structure
REQ-030 Package wb_uart_pkg holds the FSM state enum (2-bit), the UART register address constants (RX FIFO read 0x11, TX FIFO write 0x12), and the default DATA_W/ADDR_W values.
REQ-031 One sub-module, wb_arb_pick, combinationally computes the one-hot winner from the two reqs, last_grant and the mode; everything else is flat.

Verification
REQ-032 Only m0_req, write, addr 0x12, data 0x41: strobe in cycle 1 with o_wb_we=1 and addr 0x12, m0_ack in cycle 3, o_grant=01 during the transaction.
REQ-033 Only m1_req, read, addr 0x11, slave returns 0x5A in cycle 2: o_rdata=0x5A with m1_ack in cycle 3.
REQ-034 Both reqs held continuously with WB_ARB_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1, one every 4 cycles.
REQ-035 Same stimulus without the macro: m0 is granted on every round and m1 never receives an ack while m0_req is held.
REQ-036 i_rst_n pulsed low during WAIT of an m0 read: no m0_ack, all outputs 0 immediately, and a fresh m1_req after release completes normally.
REQ-037 m1_addr changed from 0x11 to 0x12 the cycle after grant: o_wb_addr stays 0x11 throughout the transaction.
